// File: rtl/bootstrap_eeprom_programmer.sv
// Page-mode programmer for the bootstrap EEPROM socket.
// Takes a byte stream over valid/ready and writes it to consecutive EEPROM
// addresses starting at 0. Each byte is stored with one N_WE pulse
// (setup / low / hold). A page is committed, followed by the write-cycle
// wait, in any of these cases:
//   - the address crosses a page boundary,
//   - the host leaves a gap longer than the byte-load window,
//   - the final byte of the image is written,
//   - the top address has been written.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no page open, ready for the first byte of a page
//   SETUP   | address/data on the bus with N_CE low, N_WE still high
//   WE_LOW  | N_WE pulse low
//   HOLD    | N_WE high again, address/data held for the device
//   NEXT    | page open, waiting for the next byte within byte-load window
//   WAIT_WC | page committed, EEPROM internal write cycle in progress
//   DONE    | image complete, bus parked until reset
module bootstrap_eeprom_programmer #(
  parameter int ADDR_WIDTH   = 17,
  parameter int PAGE_BYTES   = 64,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 1,
  parameter int BLC_CYCLES   = 64,
  parameter int TWC_CYCLES   = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_LAST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [7:0]            DATA,
  output logic                  DATA_OE,
  output logic                  N_CE,
  output logic                  N_OE,
  output logic                  N_WE,
  output logic                  BUSY,
  output logic                  DONE
);

  // One shared down-counter serves every timed state, so it is sized
  // for the longest interval. Each state loads it with (cycles - 1).
  localparam int MAX_SW  = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
  localparam int MAX_HB  = (HOLD_CYCLES > BLC_CYCLES) ? HOLD_CYCLES : BLC_CYCLES;
  localparam int MAX_SWH = (MAX_SW > MAX_HB) ? MAX_SW : MAX_HB;
  localparam int CNT_MAX = (MAX_SWH > TWC_CYCLES) ? MAX_SWH : TWC_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WE    = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_BLC   = CNT_W'(BLC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TWC   = CNT_W'(TWC_CYCLES - 1);

  localparam logic [ADDR_WIDTH-1:0] PAGE_MASK = ADDR_WIDTH'(PAGE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WE_LOW,
    S_HOLD,
    S_NEXT,
    S_WAIT_WC,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;
  logic                  data_oe_q;
  logic                  n_ce_q;
  logic                  n_we_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  last_q;
  logic                  wrap_q;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  wrap_d;
  logic                  page_end_d;
  logic                  accept;
  logic                  cnt_tc;

  // Post-write address, wrap detection and page-boundary detection.
  always_comb begin
    addr_d     = addr_q + 1'b1;
    wrap_d     = &addr_q;
    page_end_d = ((addr_d & PAGE_MASK) == '0);
    accept     = IN_VALID && in_ready_q;
    cnt_tc     = (cnt_q == '0);
  end

  // Sequencer: state, timing counter and all registered bus outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      data_oe_q  <= 1'b0;
      n_ce_q     <= 1'b1;
      n_we_q     <= 1'b1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            data_q     <= IN_DATA;
            last_q     <= IN_LAST;
            in_ready_q <= 1'b0;
            n_ce_q     <= 1'b0;
            data_oe_q  <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= LD_SETUP;
            state_q    <= S_SETUP;
          end else begin
            // ready comes up on the first clock after reset release
            in_ready_q <= 1'b1;
          end
        end

        S_SETUP: begin
          if (cnt_tc) begin
            n_we_q  <= 1'b0;
            cnt_q   <= LD_WE;
            state_q <= S_WE_LOW;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_WE_LOW: begin
          if (cnt_tc) begin
            n_we_q  <= 1'b1;
            cnt_q   <= LD_HOLD;
            state_q <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt_tc) begin
            addr_q <= addr_d;
            wrap_q <= wrap_q | wrap_d;
            if (last_q || wrap_d || page_end_d) begin
              n_ce_q    <= 1'b1;
              data_oe_q <= 1'b0;
              cnt_q     <= LD_TWC;
              state_q   <= S_WAIT_WC;
            end else begin
              in_ready_q <= 1'b1;
              cnt_q      <= LD_BLC;
              state_q    <= S_NEXT;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_NEXT: begin
          if (accept) begin
            data_q     <= IN_DATA;
            last_q     <= IN_LAST;
            in_ready_q <= 1'b0;
            cnt_q      <= LD_SETUP;
            state_q    <= S_SETUP;
          end else if (cnt_tc) begin
            // host went quiet: close the page so the device commits it
            in_ready_q <= 1'b0;
            n_ce_q     <= 1'b1;
            data_oe_q  <= 1'b0;
            cnt_q      <= LD_TWC;
            state_q    <= S_WAIT_WC;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_WAIT_WC: begin
          if (cnt_tc) begin
            busy_q <= 1'b0;
            if (last_q || wrap_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_DONE: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          n_ce_q     <= 1'b1;
          n_we_q     <= 1'b1;
          data_oe_q  <= 1'b0;
        end

        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          n_ce_q     <= 1'b1;
          n_we_q     <= 1'b1;
          data_oe_q  <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign IN_READY = in_ready_q;
  assign ADDR     = addr_q;
  assign DATA     = data_q;
  assign DATA_OE  = data_oe_q;
  assign N_CE     = n_ce_q;
  assign N_OE     = 1'b1;
  assign N_WE     = n_we_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_bootstrap_eeprom_programmer.sv
// Directed bench for the EEPROM page programmer.
// The main instance uses a 17-bit address; a small 3-bit-address instance
// covers the top-of-memory wrap. Expected writes are queued when bytes are
// accepted and popped when the bus shows the falling edge of N_WE.
module tb_bootstrap_eeprom_programmer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] addr;
  logic [7:0]  data;
  logic        data_oe, n_ce, n_oe, n_we, busy, done;

  logic [7:0]  s_in_data;
  logic        s_in_last;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [2:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_data_oe, s_n_ce, s_n_oe, s_n_we, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  logic [24:0] sb_q[$];
  int          commit_q[$];
  int          exp_commits[$];
  logic [16:0] exp_addr;

  bootstrap_eeprom_programmer #(
    .ADDR_WIDTH(17), .PAGE_BYTES(4), .SETUP_CYCLES(1), .WE_CYCLES(2),
    .HOLD_CYCLES(1), .BLC_CYCLES(8), .TWC_CYCLES(20)
  ) u_dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_LAST(in_last),
    .IN_VALID(in_valid), .IN_READY(in_ready), .ADDR(addr), .DATA(data),
    .DATA_OE(data_oe), .N_CE(n_ce), .N_OE(n_oe), .N_WE(n_we),
    .BUSY(busy), .DONE(done)
  );

  bootstrap_eeprom_programmer #(
    .ADDR_WIDTH(3), .PAGE_BYTES(4), .SETUP_CYCLES(1), .WE_CYCLES(2),
    .HOLD_CYCLES(1), .BLC_CYCLES(8), .TWC_CYCLES(20)
  ) u_small (
    .CLK(clk), .RST(rst), .IN_DATA(s_in_data), .IN_LAST(s_in_last),
    .IN_VALID(s_in_valid), .IN_READY(s_in_ready), .ADDR(s_addr), .DATA(s_data),
    .DATA_OE(s_data_oe), .N_CE(s_n_ce), .N_OE(s_n_oe), .N_WE(s_n_we),
    .BUSY(s_busy), .DONE(s_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Bus monitor for the main instance: scoreboard pops, pulse width,
  // address/data stability under N_WE and page-commit recording.
  logic        prev_nwe = 1'b1;
  logic        prev_nce = 1'b1;
  int          width = 0;
  int          pulses = 0;
  logic [16:0] p_addr;
  logic [7:0]  p_data;
  int          last_pulse_addr = 0;
  logic [24:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_nwe = 1'b1;
      prev_nce = 1'b1;
      width    = 0;
    end else begin
      chk("n_oe_high", 32'(n_oe), 32'd1);
      if (n_ce) chk("data_oe_needs_ce", 32'(data_oe), 32'd0);
      if (!n_we) chk("we_needs_ce", 32'(n_ce), 32'd0);
      if (!n_we && prev_nwe) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 32'(addr), 32'(e[24:8]));
          chk("wr_data", 32'(data), 32'(e[7:0]));
        end
        p_addr = addr;
        p_data = data;
        width  = 1;
        pulses++;
        last_pulse_addr = int'(addr);
      end else if (!n_we) begin
        chk("addr_stable", 32'(addr), 32'(p_addr));
        chk("data_stable", 32'(data), 32'(p_data));
        width++;
      end else if (!prev_nwe) begin
        chk("we_width", 32'(width), 32'd2);
      end
      if (n_ce && !prev_nce) commit_q.push_back(last_pulse_addr);
      prev_nwe = n_we;
      prev_nce = n_ce;
    end
  end

  // Monitor for the small instance: address sequence and data pattern.
  logic s_prev = 1'b1;
  int   s_pulses = 0;

  always @(negedge clk) begin
    if (rst) begin
      s_prev = 1'b1;
    end else begin
      if (!s_n_we && s_prev) begin
        chk("s_wr_addr", 32'(s_addr), 32'(s_pulses % 8));
        chk("s_wr_data", 32'(s_data), 32'(8'hC0 + 8'(s_pulses)));
        s_pulses++;
      end
      s_prev = s_n_we;
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      sb_q.push_back({exp_addr, d});
      exp_addr++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_small(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    s_in_data  = d;
    s_in_last  = 1'b0;
    s_in_valid = 1'b1;
    while (!s_in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("s_send_ready", 32'(s_in_ready), 32'd1);
    if (s_in_ready) begin
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    commit_q.delete();
    exp_addr = '0;
    rst = 1'b0;
  endtask

  task automatic measure_wc(input string tag);
    int n = 0;
    int c = 0;
    while (!(busy && n_ce) && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (busy && n_ce && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c), 32'd20);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_commits(input string tag);
    chk({tag, "_count"}, 32'(commit_q.size()), 32'(exp_commits.size()));
    for (int i = 0; i < exp_commits.size(); i++)
      chk({tag, "_addr"}, (commit_q.size() > i) ? 32'(commit_q[i]) : 32'hFFFF_FFFF,
          32'(exp_commits[i]));
  endtask

  initial begin
    int n;
    int c;
    int p0;
    logic [16:0] a0;
    logic seen_ready;
    logic [7:0] rd;

    rst        = 1'b1;
    in_data    = '0;
    in_last    = 1'b0;
    in_valid   = 1'b0;
    s_in_data  = '0;
    s_in_last  = 1'b0;
    s_in_valid = 1'b0;
    exp_addr   = '0;

    // reset values, sampled while reset is held
    repeat (2) @(negedge clk);
    chk("rst_addr",     32'(addr),     32'd0);
    chk("rst_data",     32'(data),     32'd0);
    chk("rst_data_oe",  32'(data_oe),  32'd0);
    chk("rst_n_ce",     32'(n_ce),     32'd1);
    chk("rst_n_oe",     32'(n_oe),     32'd1);
    chk("rst_n_we",     32'(n_we),     32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    rst = 1'b0;

    // one full page back-to-back
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    measure_wc("t1_wait_wc");
    chk("t1_pulses", 32'(pulses), 32'd4);
    chk("t1_addr", 32'(addr), 32'd4);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_ready", 32'(in_ready), 32'd1);
    exp_commits = '{3};
    check_commits("t1_commit");

    // two pages, last byte mid-page
    do_reset();
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_addr", 32'(addr), 32'd6);
    exp_commits = '{3, 5};
    check_commits("t2_commit");
    p0 = pulses;
    a0 = addr;
    seen_ready = 1'b0;
    in_data  = 8'hEE;
    in_valid = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (in_ready) seen_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("t2_no_accept", 32'(seen_ready), 32'd0);
    chk("t2_no_write", 32'(pulses), 32'(p0));
    chk("t2_addr_held", 32'(addr), 32'(a0));
    chk("t2_done_sticky", 32'(done), 32'd1);

    // byte-load timeout closes a partial page
    do_reset();
    send(8'h5B, 1'b0);
    send(8'h5C, 1'b0);
    n = 0;
    while (!(in_ready && !n_ce) && n < 50) begin
      @(negedge clk);
      n++;
    end
    c = 0;
    while (in_ready && !n_ce && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t3_gap", 32'(c), 32'd8);
    measure_wc("t3_wait_wc");
    exp_commits = '{1};
    check_commits("t3_commit");
    send(8'h5D, 1'b0);
    wait_idle("t3_idle");
    chk("t3_addr", 32'(addr), 32'd3);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // reset in the middle of the N_WE pulse
    do_reset();
    send(8'h5A, 1'b0);
    n = 0;
    while (n_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_we_low", 32'(n_we), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t4_n_we",    32'(n_we),    32'd1);
    chk("t4_n_ce",    32'(n_ce),    32'd1);
    chk("t4_data_oe", 32'(data_oe), 32'd0);
    chk("t4_addr",    32'(addr),    32'd0);
    do_reset();
    p0 = pulses;
    send(8'h77, 1'b0);
    n = 0;
    while (pulses == p0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_pulse_seen", 32'(pulses - p0), 32'd1);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // small instance runs off the top address
    do_reset();
    for (int i = 0; i < 8; i++) send_small(8'hC0 + 8'(i));
    n = 0;
    while (!s_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_done", 32'(s_done), 32'd1);
    chk("t5_addr_wrap", 32'(s_addr), 32'd0);
    chk("t5_busy", 32'(s_busy), 32'd0);
    chk("t5_pulses", 32'(s_pulses), 32'd8);
    seen_ready = 1'b0;
    s_in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (s_in_ready) seen_ready = 1'b1;
    end
    s_in_valid = 1'b0;
    chk("t5_no_accept", 32'(seen_ready), 32'd0);
    chk("t5_no_write", 32'(s_pulses), 32'd8);

    // randomly throttled stream of 16 bytes
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom);
      send(rd, 1'b0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle("t6_idle");
    chk("t6_pulses", 32'(pulses - p0), 32'd16);
    chk("t6_addr", 32'(addr), 32'd16);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    exp_commits = '{3, 7, 11, 15};
    check_commits("t6_commit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bootstrap_eeprom_programmer.md
Name: bootstrap_eeprom_programmer

Overview:
Writes the bootstrap image into the 128 KiB parallel EEPROM (17-bit address, 8-bit data) that the bootstrapper later reads out at power-up. It accepts a byte stream over a valid/ready handshake and places bytes at consecutive addresses from 0. It generates page-write bus cycles (N_CE/N_WE/N_OE, driven data) and enforces byte-load and write-cycle timing. It sits between the host/serial loader and the EEPROM socket on the programming board.

Parameters:
ADDR_WIDTH, 17, EEPROM address width; image wraps/ends at 2^ADDR_WIDTH
PAGE_BYTES, 64, page size (power of two); page ends when ADDR low bits wrap to 0
SETUP_CYCLES, 1, cycles ADDR/DATA valid with N_CE low before N_WE falls (>=1)
WE_CYCLES, 4, N_WE low pulse width in cycles (>=1)
HOLD_CYCLES, 1, cycles ADDR/DATA held after N_WE rises (>=1)
BLC_CYCLES, 64, max gap between bytes within an open page before the page is committed
TWC_CYCLES, 1024, write-cycle wait after each page commit

Ports:
CLK  in  1  system clock, all state changes on rising edge
RST  in  1  asynchronous active-high reset
IN_DATA  in  8  byte to write
IN_LAST  in  1  qualifies IN_DATA as final byte of the image
IN_VALID  in  1  byte offered
IN_READY  out  1  byte accepted when IN_VALID && IN_READY at CLK edge
ADDR  out  ADDR_WIDTH  EEPROM address
DATA  out  8  EEPROM write data
DATA_OE  out  1  1 = drive DATA onto EEPROM bus
N_CE  out  1  EEPROM chip enable, active low
N_OE  out  1  EEPROM output enable, active low; held high always
N_WE  out  1  EEPROM write enable, active low
BUSY  out  1  1 while a page is open or committing
DONE  out  1  sticky 1 after final page commit completes

Behaviour:
- Reset (async, immediate): state IDLE; ADDR=0, DATA=0, DATA_OE=0, N_CE=1, N_OE=1, N_WE=1, IN_READY=0 during reset, BUSY=0, DONE=0, counters and last/wrap flags cleared. Reset mid-pulse must raise N_WE in the same instant (no glitch low).
- N_OE is 1 in every state; DATA_OE is 1 only when N_CE=0.
- States: IDLE, SETUP, WE_LOW, HOLD, NEXT, WAIT_WC, DONE.
- IDLE: IN_READY=1, BUSY=0, N_CE=1. On accept: latch DATA=IN_DATA, last flag=IN_LAST -> SETUP. Waits indefinitely.
- SETUP: N_CE=0, DATA_OE=1, N_WE=1, BUSY=1 for SETUP_CYCLES -> WE_LOW.
- WE_LOW: N_WE=0 for exactly WE_CYCLES -> HOLD. ADDR/DATA stable throughout.
- HOLD: N_WE=1, ADDR/DATA held HOLD_CYCLES. Then ADDR increments (mod 2^ADDR_WIDTH; wrap to 0 sets wrap flag). If last flag, wrap flag, or new ADDR mod PAGE_BYTES == 0 -> WAIT_WC; else -> NEXT.
- NEXT: N_CE=0, N_WE=1, IN_READY=1, gap counter runs. Accept -> latch byte/last -> SETUP (counter cleared). Counter reaches BLC_CYCLES with no accept -> WAIT_WC.
- WAIT_WC: N_CE=1, DATA_OE=0, IN_READY=0, BUSY=1 for TWC_CYCLES. Then last or wrap flag -> DONE, else -> IDLE.
- DONE: DONE=1, BUSY=0, IN_READY=0, bus idle; only RST leaves.
- Byte latency: accept edge to N_WE fall = SETUP_CYCLES cycles; per-byte period inside a page = SETUP+WE+HOLD+1 (NEXT) cycles minimum.
- IN_LAST on the byte at a page boundary: single WAIT_WC, then DONE.
- IN_VALID high in WAIT_WC/DONE: not accepted; stream stalls, no byte lost or duplicated.
- Writing address 2^ADDR_WIDTH-1 ends the image (DONE) regardless of IN_LAST.

Test Plan:
(Bench params: PAGE_BYTES=4, SETUP=1, WE=2, HOLD=1, BLC=8, TWC=20.)
- Reset then bytes 0x11,0x22,0x33,0x44 back-to-back -> four N_WE pulses each 2 cycles low at ADDR 0..3 with matching DATA; one 20-cycle WAIT_WC with N_CE=1; return to IDLE, ADDR=4, DONE=0.
- 6 bytes 0xA0..0xA5, IN_LAST on 0xA5 -> commits at ADDR 3 and ADDR 5; DONE=1 after second WAIT_WC; later IN_VALID never accepted.
- Two bytes, then IN_VALID low 10 cycles -> page committed after 8-cycle gap, WAIT_WC 20 cycles, third byte written at ADDR 2 in new page.
- Assert RST while N_WE=0 in WE_LOW -> N_WE, N_CE high and DATA_OE low immediately; after release, first byte goes to ADDR 0.
- Preload via stream to ADDR 2^17-1 (ADDR_WIDTH=3 variant: 8 bytes, no IN_LAST) -> DONE after commit of ADDR 7, ADDR wraps to 0.
- Random IN_VALID throttling with gaps <8 over 16 bytes -> scoreboard memory model matches every byte; N_OE never low; N_WE low only when N_CE low with stable ADDR/DATA.
